// File: rtl/byte_packer.sv
// Byte-to-word packer: gathers a byte stream into 32-bit words with a one-deep
// output register and a single-word holding slot (PEND) for backpressure.
module byte_packer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes,
    input  logic        out_ready
);

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state_reg;
    logic [1:0]  cnt_reg;
    logic [31:0] asm_reg;
    logic [2:0]  pend_bytes_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic [31:0] out_data_reg;
    logic [2:0]  out_bytes_reg;

    logic [1:0]  lane_sel;
    logic [31:0] merged_word;
    logic [2:0]  fill_bytes;
    logic        accept;
    logic        take;
    logic        closing;
    logic        slot_free;

    assign accept     = in_valid && in_ready_reg;
    assign take       = out_valid_reg && out_ready;
    assign closing    = in_last || (cnt_reg == 2'd3);
    assign slot_free  = !out_valid_reg || out_ready;
    assign fill_bytes = {1'b0, cnt_reg} + 3'd1;
    assign lane_sel   = MSB_FIRST ? (2'd3 - cnt_reg) : cnt_reg;

    // Lanes not yet written are still zero in asm_reg, which gives the zero fill on flush.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[gi*8 +: 8] = (lane_sel == 2'(gi)) ? in_data : asm_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FILL;
            cnt_reg        <= 2'd0;
            asm_reg        <= 32'd0;
            pend_bytes_reg <= 3'd0;
            in_ready_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= 32'd0;
            out_bytes_reg  <= 3'd0;
        end else begin
            // A take empties the output slot unless a new word reloads it below.
            if (take) begin
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                FILL: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        if (closing) begin
                            if (slot_free) begin
                                out_data_reg  <= merged_word;
                                out_bytes_reg <= fill_bytes;
                                out_valid_reg <= 1'b1;
                                cnt_reg       <= 2'd0;
                                asm_reg       <= 32'd0;
                            end else begin
                                asm_reg        <= merged_word;
                                pend_bytes_reg <= fill_bytes;
                                state_reg      <= PEND;
                                in_ready_reg   <= 1'b0;
                            end
                        end else begin
                            asm_reg <= merged_word;
                            cnt_reg <= cnt_reg + 2'd1;
                        end
                    end
                end
                PEND: begin
                    // out_valid is always 1 here, so out_ready alone means the slot frees.
                    if (out_ready) begin
                        out_data_reg  <= asm_reg;
                        out_bytes_reg <= pend_bytes_reg;
                        out_valid_reg <= 1'b1;
                        asm_reg       <= 32'd0;
                        cnt_reg       <= 2'd0;
                        state_reg     <= FILL;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= FILL;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_bytes = out_bytes_reg;

endmodule

// File: tb/tb_byte_packer.sv
// Bench for byte_packer: both lane orders side by side, directed cases plus a
// randomized run against a word-queue reference model.
module tb_byte_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_m, out_valid_m, in_ready_l, out_valid_l;
    logic [31:0] out_data_m, out_data_l;
    logic [2:0]  out_bytes_m, out_bytes_l;

    byte_packer #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready_m), .out_valid(out_valid_m),
        .out_data(out_data_m), .out_bytes(out_bytes_m), .out_ready(out_ready)
    );

    byte_packer #(.MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready_l), .out_valid(out_valid_l),
        .out_data(out_data_l), .out_bytes(out_bytes_l), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: completed words wait in a queue (byte k kept at [8k+:8]).
    typedef struct packed {
        logic [31:0] b;
        logic [2:0]  n;
    } word_t;

    word_t       exp_q[$];
    logic [31:0] cur_b;
    int          cur_n;
    int          n_checks;
    int          n_fail;
    int          n_words;

    function automatic logic [31:0] pack_word(input logic [31:0] b, input logic [2:0] n, input bit msb);
        logic [31:0] d;
        d = 32'd0;
        for (int k = 0; k < int'(n); k++) begin
            if (msb) d[31-8*k -: 8] = b[8*k +: 8];
            else     d[8*k +: 8]    = b[8*k +: 8];
        end
        return d;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        cur_b = 32'd0;
        cur_n = 0;
    endtask

    // One clock of stimulus; handshakes are judged on values seen before the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
        logic        acc, tk, hold;
        logic [31:0] pd_m, pd_l;
        logic [2:0]  pb_m, pb_l;
        word_t       w;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
        acc  = in_valid && in_ready_m;
        tk   = out_valid_m && out_ready;
        hold = out_valid_m && !out_ready;
        pd_m = out_data_m;
        pd_l = out_data_l;
        pb_m = out_bytes_m;
        pb_l = out_bytes_l;
        @(posedge clk);
        #1;
        if (tk) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_word", 32'(exp_q.size()), 32'd1);
            end else begin
                w = exp_q.pop_front();
                n_words++;
                $display("word %0d: data_m %h data_l %h bytes %0d", n_words, pd_m, pd_l, pb_m);
                check_eq("word_data_msb", pd_m, pack_word(w.b, w.n, 1'b1));
                check_eq("word_data_lsb", pd_l, pack_word(w.b, w.n, 1'b0));
                check_eq("word_bytes_msb", 32'(pb_m), 32'(w.n));
                check_eq("word_bytes_lsb", 32'(pb_l), 32'(w.n));
            end
        end
        if (acc) begin
            cur_b[8*cur_n +: 8] = d;
            cur_n++;
            if (l || cur_n == 4) begin
                w.b = cur_b;
                w.n = 3'(cur_n);
                exp_q.push_back(w);
                cur_b = 32'd0;
                cur_n = 0;
            end
        end
        check_eq("out_valid_msb", 32'(out_valid_m), 32'(exp_q.size() > 0));
        check_eq("out_valid_lsb", 32'(out_valid_l), 32'(exp_q.size() > 0));
        check_eq("in_ready_msb", 32'(in_ready_m), 32'(exp_q.size() < 2));
        check_eq("in_ready_lsb", 32'(in_ready_l), 32'(exp_q.size() < 2));
        if (hold) begin
            check_eq("hold_data_msb", out_data_m, pd_m);
            check_eq("hold_data_lsb", out_data_l, pd_l);
            check_eq("hold_bytes_msb", 32'(out_bytes_m), 32'(pb_m));
            check_eq("hold_bytes_lsb", 32'(out_bytes_l), 32'(pb_l));
        end
    endtask

    // Asserts reset between edges, checks outputs cleared with no edge, then releases.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid_m), 32'd0);
        check_eq("rst_out_data", out_data_m, 32'd0);
        check_eq("rst_out_bytes", 32'(out_bytes_m), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready_m), 32'd0);
        check_eq("rst_out_valid_lsb", 32'(out_valid_l), 32'd0);
        check_eq("rst_in_ready_lsb", 32'(in_ready_l), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_in_ready", 32'(in_ready_m), 32'd1);
        check_eq("rel_out_valid", 32'(out_valid_m), 32'd0);
        model_clear();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_words   = 0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        model_clear();
        do_reset();

        // Full word, consumer always ready
        step(1'b1, 8'h12, 1'b0, 1'b1);
        step(1'b1, 8'h34, 1'b0, 1'b1);
        step(1'b1, 8'h56, 1'b0, 1'b1);
        step(1'b1, 8'h78, 1'b0, 1'b1);
        check_eq("full_msb", out_data_m, 32'h12345678);
        check_eq("full_lsb", out_data_l, 32'h78563412);
        check_eq("full_bytes", 32'(out_bytes_m), 32'd4);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("full_one_cycle", 32'(out_valid_m), 32'd0);

        // Flush with in_last, then a single-byte word
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        step(1'b1, 8'hBB, 1'b1, 1'b1);
        check_eq("flush_msb", out_data_m, 32'hAABB0000);
        check_eq("flush_lsb", out_data_l, 32'h0000BBAA);
        check_eq("flush_bytes", 32'(out_bytes_m), 32'd2);
        step(1'b1, 8'hCC, 1'b1, 1'b1);
        check_eq("single_msb", out_data_m, 32'hCC000000);
        check_eq("single_lsb", out_data_l, 32'h000000CC);
        check_eq("single_bytes", 32'(out_bytes_m), 32'd1);

        // in_last without in_valid is ignored
        step(1'b1, 8'h11, 1'b0, 1'b1);
        step(1'b0, 8'h99, 1'b1, 1'b1);
        step(1'b1, 8'h22, 1'b1, 1'b1);
        check_eq("ignored_last_msb", out_data_m, 32'h11220000);
        check_eq("ignored_last_bytes", 32'(out_bytes_m), 32'd2);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure: two words, second one waits in PEND
        for (int k = 1; k <= 8; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
        check_eq("bp_held_data", out_data_m, 32'h01020304);
        check_eq("bp_in_ready_low", 32'(in_ready_m), 32'd0);
        step(1'b1, 8'h09, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("bp_second_word", out_data_m, 32'h05060708);
        check_eq("bp_in_ready_back", 32'(in_ready_m), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset while a word is pending
        for (int k = 1; k <= 8; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) != 0));
        end
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
